imem_sync: RTL and testbench

- Parametrised, synchronous successor to the combinational instruction memory.
- Word-organised instruction store with one registered read port feeding the IF/ID boundary, plus a program-load write port for bench/boot loading.
- Adds request/valid handshake, stall hold, branch flush, misalignment and out-of-range detection.
- Sits between PC logic and the IF/ID pipeline register.

---
 rtl/imem_sync.sv | 125 ++++++++++++
 tb/tb_imem_sync.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// imem_sync: word-organised instruction store, one registered fetch port, one load port.
// Latency: 1 cycle from req to instr/instr_valid; loads commit on the same clock edge.
// Backpressure: stall holds all output registers; flush clears them; flush > stall > req.
// Optional: define IMEM_PARITY_EN to add per-word even parity, parity_err and parity_err_inject.

module imem_sync #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 32,
  parameter int          DEPTH    = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic              parity_err_inject,
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              misaligned,
  output logic              out_of_range
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0] mem [DEPTH];

  // Address decode: word index plus the bits above it, which must all be zero
  // for the access to be in range (addresses never wrap into the array).
  logic [IDX_W-1:0]  rd_idx, ld_idx;
  logic [ADDR_W-1:0] rd_hi, ld_hi;
  logic              rd_mis, rd_oor, ld_ok;
  logic [MEM_W-1:0]  rd_word;
  logic              rd_perr;

  assign rd_idx  = read_address[IDX_W+1:2];
  assign ld_idx  = load_addr[IDX_W+1:2];
  assign rd_hi   = read_address >> (IDX_W + 2);
  assign ld_hi   = load_addr >> (IDX_W + 2);
  assign rd_mis  = (read_address[1:0] != 2'b00);
  assign rd_oor  = (rd_hi != '0);
  assign ld_ok   = (load_addr[1:0] == 2'b00) && (ld_hi == '0);
  assign rd_word = mem[rd_idx];

`ifdef IMEM_PARITY_EN
  // Stored word is {parity, data} with even parity, so a clean word XORs to 0.
  // Only judged for fetches that actually address a real word.
  assign rd_perr = (^rd_word) && !rd_mis && !rd_oor;
`else
  assign rd_perr = 1'b0;
`endif

  // Load port: aligned, in-range writes only; ignored while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && load_en && ld_ok) begin
`ifdef IMEM_PARITY_EN
      mem[ld_idx] <= {(^load_data) ^ parity_err_inject, load_data};
`else
      mem[ld_idx] <= load_data;
`endif
    end
  end

  logic [DATA_W-1:0] instr_nxt;
  logic              valid_nxt, mis_nxt, oor_nxt, perr_nxt, perr_q;

`ifdef IMEM_PARITY_EN
  assign parity_err = perr_q;
`endif

  // Next output state: flush clears, stall holds, req fetches, idle drives NOP.
  always_comb begin
    instr_nxt = NOP_WORD;
    valid_nxt = 1'b0;
    mis_nxt   = 1'b0;
    oor_nxt   = 1'b0;
    perr_nxt  = 1'b0;
    if (flush) begin
      instr_nxt = NOP_WORD;
    end else if (stall) begin
      instr_nxt = instr;
      valid_nxt = instr_valid;
      mis_nxt   = misaligned;
      oor_nxt   = out_of_range;
      perr_nxt  = perr_q;
    end else if (req) begin
      valid_nxt = 1'b1;
      mis_nxt   = rd_mis;
      oor_nxt   = rd_oor;
      perr_nxt  = rd_perr;
      // A faulted fetch still reports valid so the pipeline can trap on the flags.
      instr_nxt = (rd_mis || rd_oor || rd_perr) ? NOP_WORD : rd_word[DATA_W-1:0];
    end
  end

  // Output registers; read happens before the same-edge load, giving old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr        <= NOP_WORD;
      instr_valid  <= 1'b0;
      misaligned   <= 1'b0;
      out_of_range <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      instr        <= instr_nxt;
      instr_valid  <= valid_nxt;
      misaligned   <= mis_nxt;
      out_of_range <= oor_nxt;
      perr_q       <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Directed bench for imem_sync: load/fetch, stall hold, faults, read-before-write,
// flush priority, async reset and (with IMEM_PARITY_EN) parity error handling.
module tb_imem_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, stall, flush, load_en;
  logic [31:0] read_address, load_addr, load_data;
  logic [31:0] instr;
  logic        instr_valid, misaligned, out_of_range;
`ifdef IMEM_PARITY_EN
  logic        parity_err_inject, parity_err;
`endif

  int tests = 0;
  int fails = 0;

  imem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset), .req(req), .read_address(read_address),
    .stall(stall), .flush(flush), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .parity_err_inject(parity_err_inject), .parity_err(parity_err),
`endif
    .instr(instr), .instr_valid(instr_valid), .misaligned(misaligned),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the edge, then inputs may change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req = 1'b1; read_address = a;
    tick();
    req = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] i, input logic v,
                           input logic m, input logic o);
    check({tag, ".instr"}, 64'(instr), 64'(i));
    check({tag, ".valid"}, 64'(instr_valid), 64'(v));
    check({tag, ".mis"},   64'(misaligned), 64'(m));
    check({tag, ".oor"},   64'(out_of_range), 64'(o));
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; stall = 1'b0; flush = 1'b0; load_en = 1'b0;
    read_address = '0; load_addr = '0; load_data = '0;
`ifdef IMEM_PARITY_EN
    parity_err_inject = 1'b0;
`endif
    #1;
    check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b0;

    load(32'h0,   32'hAD0A0008);
    load(32'h4,   32'h8D0B0000);
    load(32'h8,   32'h00000000);
    load(32'hFFC, 32'hCAFEF00D);

    // Back-to-back fetches, one cycle latency each.
    req = 1'b1; read_address = 32'h0;
    tick();
    check_out("f0", 32'hAD0A0008, 1'b1, 1'b0, 1'b0);
    read_address = 32'h4;
    tick();
    check_out("f4", 32'h8D0B0000, 1'b1, 1'b0, 1'b0);

    // Stall holds for 3 cycles although the address changes.
    stall = 1'b1; read_address = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("stall", 32'h8D0B0000, 1'b1, 1'b0, 1'b0);
    end
    stall = 1'b0;
    tick();
    check_out("unstall", 32'hAD0A0008, 1'b1, 1'b0, 1'b0);
    req = 1'b0;

    // Fault flags and the last in-range word.
    fetch(32'h2);    check_out("mis",     32'h0, 1'b1, 1'b1, 1'b0);
    fetch(32'h1000); check_out("oor",     32'h0, 1'b1, 1'b0, 1'b1);
    fetch(32'h1002); check_out("mis_oor", 32'h0, 1'b1, 1'b1, 1'b1);
    fetch(32'hFFC);  check_out("last",    32'hCAFEF00D, 1'b1, 1'b0, 1'b0);

    // Idle cycle clears everything.
    tick();
    check_out("idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Dropped loads: out-of-range (would alias word 0) and misaligned (word 1).
    load(32'h1000, 32'h11111111);
    load(32'h5,    32'hDEADBEEF);
    fetch(32'h0); check_out("drop_oor", 32'hAD0A0008, 1'b1, 1'b0, 1'b0);
    fetch(32'h4); check_out("drop_mis", 32'h8D0B0000, 1'b1, 1'b0, 1'b0);

    // Same-cycle load and fetch returns old contents.
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'h01404820;
    req = 1'b1; read_address = 32'h8;
    tick();
    load_en = 1'b0;
    check_out("rbw_old", 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check_out("rbw_new", 32'h01404820, 1'b1, 1'b0, 1'b0);

    // Flush beats stall and req.
    flush = 1'b1; stall = 1'b1; read_address = 32'h0;
    tick();
    check_out("flush", 32'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0; stall = 1'b0; req = 1'b0;

    // Async reset during stall, with a load that must be ignored.
    fetch(32'h4);
    stall = 1'b1;
    tick();
    check_out("pre_rst", 32'h8D0B0000, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'h11111111;
    #1;
    check_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    load_en = 1'b0; stall = 1'b0;
    reset = 1'b0;
    fetch(32'h0); check_out("rst_load", 32'hAD0A0008, 1'b1, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
    parity_err_inject = 1'b1;
    load(32'hC, 32'h12110003);
    parity_err_inject = 1'b0;
    fetch(32'hC);
    check_out("perr_bad", 32'h0, 1'b1, 1'b0, 1'b0);
    check("perr_bad.flag", 64'(parity_err), 64'd1);
    load(32'hC, 32'h12110003);
    fetch(32'hC);
    check_out("perr_ok", 32'h12110003, 1'b1, 1'b0, 1'b0);
    check("perr_ok.flag", 64'(parity_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
